demux32bit_1x2_buf: RTL and testbench
=====================================

# demux32bit_1x2_buf

Buffered 1-to-2 steering block for 32-bit datapath values, the distribution counterpart of the 2:1 32-bit select mux. One valid/ready input stream is routed by a per-word select bit into one of two independently buffered valid/ready output streams. Each output has its own small FIFO, so one stalled consumer does not block words bound for the other. It sits between a single producer (e.g. a result bus) and two consumers (e.g. two writeback or queue ports).

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 2, entries per output FIFO; power of two, >= 2
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  producer has a word
- in_ready  output  1  selected output FIFO can accept
- in_data  input  WIDTH  word to steer
- in_sel  input  1  destination: 0 = out0, 1 = out1
- out0_valid  output  1  out0 FIFO non-empty
- out0_ready  input  1  consumer 0 accepts head
- out0_data  output  WIDTH  out0 FIFO head
- out1_valid, out1_ready, out1_data: same as out0 for destination 1
- out0_count, out1_count  output  log2(DEPTH)+1  current occupancy

## Operation
- Input transfer: in_valid & in_ready on a rising edge; word written to FIFO[in_sel] tail.
- in_ready = (in_sel ? count1 : count0) < DEPTH. Depends only on in_sel and registered counts; no combinational path from out*_ready to in_ready.
- in_sel and in_data must be stable while in_valid is high and in_ready is low (producer rule; bench asserts it).
- Output transfer per FIFO: outN_valid & outN_ready; head popped, read pointer advances.
- outN_valid = (countN != 0); outN_data = storage[rd_ptrN]; driven from registers only.
- Per-FIFO order preserved; no ordering guarantee between out0 and out1.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH naturally. Count: log2(DEPTH)+1 bits, range 0..DEPTH.
- Simultaneous push and pop on same FIFO: count unchanged, both pointers advance. Legal at any count in 1..DEPTH-1. At count = DEPTH push is refused (in_ready low) even if a pop occurs that cycle. At count = 0 the word is not bypassed; it appears next cycle.
- Pop while empty, push while full: cannot occur (gated by valid/ready); FIFO ignores outN_ready when empty.
- Reset (asynchronous, any time including mid-transfer): counts = 0, pointers = 0, out*_valid = 0, out*_data = 0 (storage cleared), in_ready = 1. In-flight words are discarded.

## Timing
- Latency: word accepted at edge k is visible on outN_data with outN_valid high after edge k (one cycle, registered).
- Throughput: one input word per cycle sustained while the target consumer drains one per cycle; both outputs may pop in the same cycle.
- outN_count updates on the same edge as the push/pop.
- Reset deassertion: first accept possible on the first rising edge with rst_n high.

## Structure
- Shared header (`define file): DP_WIDTH = 32, used for the WIDTH default. No other shared constants.
- One sub-module, fifo_buf (WIDTH, DEPTH; push/data_in/full, pop/data_out/empty/count), instantiated twice. Top level holds only the steering: push0 = in_valid & in_ready & ~in_sel, push1 = in_valid & in_ready & in_sel, in_ready mux.
- Storage in flops; no memory macro.

## Test plan
- Reset then alternate in_sel 0,1,0,1 with data 0x11111111..0x44444444, both readies high -> out0 sees 0x11111111, 0x33333333; out1 sees 0x22222222, 0x44444444; each one cycle after accept.
- out0_ready low, send 3 words with in_sel=0 -> first 2 accepted, out0_count = 2, in_ready low on third; a word with in_sel=1 presented next is accepted and appears on out1.
- Full FIFO (count 2) with out0_ready high and in_valid/in_sel=0 in same cycle -> pop occurs, push refused, count goes 1; push accepted next cycle, count back to 2.
- Count 1, simultaneous push and pop on out1 for 8 cycles with incrementing data -> count stays 1, outputs in order, pointers wrap without loss.
- Assert rst_n low mid-stream with both FIFOs holding data -> asynchronously out*_valid = 0, counts = 0, data = 0, in_ready = 1; no stale word appears after release.

Source files
------------

// File: rtl/demux32bit_1x2_buf_pkg.sv
// Shared types for the buffered 1-to-2 steering block.
`ifndef DP_WIDTH
`define DP_WIDTH 32
`endif

package demux32bit_1x2_buf_pkg;

    typedef enum logic {
        DST_OUT0 = 1'b0,
        DST_OUT1 = 1'b1
    } dst_e;

    // Occupancy needs one bit more than the pointers to represent "full".
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/demux32bit_1x2_buf_if.sv
// Producer-side stream plus both consumer-side streams of the steering block.
interface demux32bit_1x2_buf_if
    import demux32bit_1x2_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int CW = cnt_w(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic [CW-1:0]    out0_count;
    logic [CW-1:0]    out1_count;

    modport master (
        output in_valid, in_data, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data,
               out0_count, out1_count
    );

    modport slave (
        input  in_valid, in_data, in_sel, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data,
               out0_count, out1_count
    );
endinterface

// File: rtl/demux32bit_1x2_buf_fifo_buf.sv
// Purpose: flop-based FIFO buffering one output stream of the steering block.
// Latency: one cycle push-to-head; no bypass when empty.
// Backpressure: full refuses push even when a pop happens the same cycle.
module fifo_buf
    import demux32bit_1x2_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data_out,
    output logic                     empty,
    output logic [cnt_w(DEPTH)-1:0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            // Push and pop together leave occupancy unchanged.
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/demux32bit_1x2_buf.sv
// Purpose: steer one valid/ready word stream into two independently buffered outputs.
// Latency: one cycle from input accept to the selected output head.
// Backpressure: in_ready reflects only the selected FIFO's registered fullness.
module demux32bit_1x2_buf
    import demux32bit_1x2_buf_pkg::*;
#(
    parameter int WIDTH = `DP_WIDTH,
    parameter int DEPTH = 2
)(
    input  logic                  clk,
    input  logic                  rst_n,
    demux32bit_1x2_buf_if.slave   bus
);
    dst_e dst;
    logic full0, full1;
    logic empty0, empty1;
    logic push0, push1;

    assign dst          = dst_e'(bus.in_sel);
    assign bus.in_ready = (dst == DST_OUT1) ? ~full1 : ~full0;
    assign push0        = bus.in_valid & bus.in_ready & (dst == DST_OUT0);
    assign push1        = bus.in_valid & bus.in_ready & (dst == DST_OUT1);
    assign bus.out0_valid = ~empty0;
    assign bus.out1_valid = ~empty1;

    fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push0),
        .data_in  (bus.in_data),
        .full     (full0),
        .pop      (bus.out0_ready),
        .data_out (bus.out0_data),
        .empty    (empty0),
        .count    (bus.out0_count)
    );

    fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push1),
        .data_in  (bus.in_data),
        .full     (full1),
        .pop      (bus.out1_ready),
        .data_out (bus.out1_data),
        .empty    (empty1),
        .count    (bus.out1_count)
    );
endmodule

// File: tb/tb_demux32bit_1x2_buf.sv
// Directed bench for the buffered 1-to-2 steering block.
module tb_demux32bit_1x2_buf;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    demux32bit_1x2_buf_if #(.WIDTH(32), .DEPTH(2)) bus ();

    demux32bit_1x2_buf #(.WIDTH(32), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic sel, input logic [31:0] d,
                         input logic r0, input logic r1);
        bus.in_valid   = v;
        bus.in_sel     = sel;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Producer must hold sel/data while stalled.
    logic        p_stall = 1'b0;
    logic        p_sel = 1'b0;
    logic [31:0] p_data = '0;
    always @(posedge clk) begin
        if (rst_n && p_stall && bus.in_valid &&
            (bus.in_sel !== p_sel || bus.in_data !== p_data)) begin
            errors++;
            $display("FAIL producer_hold sel %0b data %0h held %0b %0h",
                     bus.in_sel, bus.in_data, p_sel, p_data);
        end
        p_stall = rst_n && bus.in_valid && !bus.in_ready;
        p_sel   = bus.in_sel;
        p_data  = bus.in_data;
    end

    initial begin
        drive(0, 0, 32'h0, 0, 0);
        #3;
        chk("rst_in_ready",   bus.in_ready,   1);
        chk("rst_out0_valid", bus.out0_valid, 0);
        chk("rst_out1_valid", bus.out1_valid, 0);
        chk("rst_out0_count", bus.out0_count, 0);
        chk("rst_out1_data",  bus.out1_data,  0);
        tick();
        rst_n = 1'b1;

        // Alternating steering, both consumers ready.
        drive(1, 0, 32'h11111111, 1, 1);
        tick();
        chk("alt_o0_valid", bus.out0_valid, 1);
        chk("alt_o0_data",  bus.out0_data,  32'h11111111);
        chk("alt_o1_idle",  bus.out1_valid, 0);
        drive(1, 1, 32'h22222222, 1, 1);
        tick();
        chk("alt_o1_data",  bus.out1_data,  32'h22222222);
        chk("alt_o0_drain", bus.out0_valid, 0);
        drive(1, 0, 32'h33333333, 1, 1);
        tick();
        chk("alt_o0_data2", bus.out0_data,  32'h33333333);
        chk("alt_o1_drain", bus.out1_valid, 0);
        drive(1, 1, 32'h44444444, 1, 1);
        tick();
        chk("alt_o1_data2", bus.out1_data,  32'h44444444);
        chk("alt_o0_empty", bus.out0_valid, 0);
        drive(0, 0, 32'h0, 1, 1);
        tick();
        chk("alt_o1_empty", bus.out1_valid, 0);

        // Fill out0 while its consumer stalls; out1 stays open.
        drive(1, 0, 32'hA1, 0, 1);
        #1 chk("fill_rdy1", bus.in_ready, 1);
        tick();
        chk("fill_cnt1", bus.out0_count, 1);
        drive(1, 0, 32'hA2, 0, 1);
        tick();
        chk("fill_cnt2", bus.out0_count, 2);
        drive(1, 0, 32'hA3, 0, 1);
        #1 chk("fill_blocked", bus.in_ready, 0);
        tick();
        chk("fill_cnt_hold", bus.out0_count, 2);
        chk("fill_head",     bus.out0_data,  32'hA1);
        drive(0, 0, 32'h0, 0, 1);
        tick();
        drive(1, 1, 32'hB1, 0, 1);
        #1 chk("other_rdy", bus.in_ready, 1);
        tick();
        chk("other_o1_valid", bus.out1_valid, 1);
        chk("other_o1_data",  bus.out1_data,  32'hB1);

        // Full FIFO: pop happens, push refused; push lands next cycle.
        drive(1, 0, 32'hA3, 1, 1);
        #1 chk("full_rdy_low", bus.in_ready, 0);
        tick();
        chk("full_cnt_pop",  bus.out0_count, 1);
        chk("full_head",     bus.out0_data,  32'hA2);
        chk("full_o1_drain", bus.out1_count, 0);
        drive(1, 0, 32'hA3, 0, 1);
        tick();
        chk("full_cnt_back", bus.out0_count, 2);
        drive(0, 0, 32'h0, 1, 1);
        tick();
        chk("drain_head", bus.out0_data, 32'hA3);
        tick();
        chk("drain_cnt0", bus.out0_count, 0);

        // Streaming through out1 at occupancy 1; pointers wrap several times.
        drive(1, 1, 32'hC0, 1, 0);
        tick();
        chk("strm_cnt_start", bus.out1_count, 1);
        for (int i = 1; i <= 8; i++) begin
            drive(1, 1, 32'hC0 + i, 1, 1);
            tick();
            chk("strm_cnt",  bus.out1_count, 1);
            chk("strm_data", bus.out1_data,  32'hC0 + i);
        end
        drive(0, 0, 32'h0, 1, 1);
        tick();
        chk("strm_end_cnt", bus.out1_count, 0);

        // Asynchronous reset with both FIFOs holding data.
        drive(1, 0, 32'hD0, 0, 0);
        tick();
        drive(1, 1, 32'hD1, 0, 0);
        tick();
        drive(1, 0, 32'hD2, 0, 0);
        tick();
        chk("pre_rst_cnt0", bus.out0_count, 2);
        chk("pre_rst_cnt1", bus.out1_count, 1);
        drive(0, 1, 32'h0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_o0_valid", bus.out0_valid, 0);
        chk("arst_o1_valid", bus.out1_valid, 0);
        chk("arst_cnt0",     bus.out0_count, 0);
        chk("arst_cnt1",     bus.out1_count, 0);
        chk("arst_o0_data",  bus.out0_data,  0);
        chk("arst_o1_data",  bus.out1_data,  0);
        chk("arst_in_ready", bus.in_ready,   1);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 32'h0, 1, 1);
        tick();
        chk("post_rst_o0", bus.out0_valid, 0);
        chk("post_rst_o1", bus.out1_valid, 0);
        drive(1, 1, 32'hE0, 0, 1);
        tick();
        chk("post_rst_push", bus.out1_data,  32'hE0);
        chk("post_rst_cnt",  bus.out1_count, 1);
        drive(0, 0, 32'h0, 1, 1);
        tick();
        chk("post_rst_drain", bus.out1_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
